// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand stage and the ALU itself:
// default widths, ALU function encodings and skid-buffer occupancy states.
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int IMM_W  = 16;
  localparam int FUNC_W = 4;

  // ALU function codes; the ALU decodes the same values.
  localparam logic [FUNC_W-1:0] FUNC_AND = 4'd0;
  localparam logic [FUNC_W-1:0] FUNC_OR  = 4'd1;
  localparam logic [FUNC_W-1:0] FUNC_ADD = 4'd2;
  localparam logic [FUNC_W-1:0] FUNC_SUB = 4'd3;
  localparam logic [FUNC_W-1:0] FUNC_XOR = 4'd4;
  localparam logic [FUNC_W-1:0] FUNC_SLL = 4'd5;
  localparam logic [FUNC_W-1:0] FUNC_SRL = 4'd6;
  localparam logic [FUNC_W-1:0] FUNC_SRA = 4'd7;

  // Skid buffer occupancy.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/alu_skid_buf.sv
// Generic 2-entry valid/ready skid buffer. The main entry drives the output;
// the skid entry absorbs the one beat that can arrive after downstream stalls,
// which lets in_ready come straight from a flop.
module alu_skid_buf
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  occ_e             state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_fire;
  logic             out_fire;

  assign out_valid = (state_q != OCC_EMPTY);
  assign in_ready  = in_ready_q;
  assign out_data  = main_q;
  assign in_fire   = in_valid && in_ready_q;
  assign out_fire  = out_valid && out_ready;

  // Occupancy transitions and entry movement; in_ready is precomputed from the next state.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      OCC_EMPTY: begin
        if (in_fire) begin
          main_d  = in_data;
          state_d = OCC_ONE;
        end
      end
      OCC_ONE: begin
        if (in_fire && out_fire) begin
          main_d = in_data;
        end else if (in_fire) begin
          skid_d  = in_data;
          state_d = OCC_FULL;
        end else if (out_fire) begin
          state_d = OCC_EMPTY;
        end
      end
      OCC_FULL: begin
        // in_ready is low here, so only the drain can happen.
        if (out_fire) begin
          main_d  = skid_q;
          state_d = OCC_ONE;
        end
      end
      default: state_d = OCC_EMPTY;
    endcase
    // Flush drops everything, including a beat arriving this cycle; the data
    // registers keep their values since they are don't-care while empty.
    if (flush) begin
      state_d = OCC_EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end
    in_ready_d = (state_d != OCC_FULL);
  end

  // State and data registers; reset clears everything, including the data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= OCC_EMPTY;
      in_ready_q <= 1'b1;
      main_q     <= '0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// Operand stage in front of the ALU: forms A (rs_data) and B (rt_data or the
// sign-extended immediate) at capture and hands {A, B, func} to the ALU via a
// 2-entry skid buffer. Optional macro STALL_CNT_EN adds a saturating counter
// of cycles where the output is valid but not accepted.
module alu_operand_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int IMM_W  = alu_pkg::IMM_W,
  parameter int FUNC_W = alu_pkg::FUNC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic [IMM_W-1:0]  imm,
  input  logic              use_imm,
  input  logic [FUNC_W-1:0] func,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [FUNC_W-1:0] alu_func
`ifdef STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  localparam int ENTRY_W = DATA_W * 2 + FUNC_W;

  logic [DATA_W-1:0]  b_formed;
  logic [ENTRY_W-1:0] in_entry;
  logic [ENTRY_W-1:0] out_entry;

  // Operand B selection; the immediate is sign-extended to the datapath width.
  always_comb begin
    b_formed = use_imm ? {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm} : rt_data;
    in_entry = {rs_data, b_formed, func};
  end

  alu_skid_buf #(
    .WIDTH(ENTRY_W)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_entry),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_entry)
  );

  assign alu_a    = out_entry[ENTRY_W-1 -: DATA_W];
  assign alu_b    = out_entry[FUNC_W +: DATA_W];
  assign alu_func = out_entry[FUNC_W-1:0];

`ifdef STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Count stalled cycles, saturating at all-ones; flush does not affect it.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Counter register, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Pipeline stage directly upstream of the 32-bit ALU (AND/OR/ADD/... units).
- Accepts decoded instruction fields plus register-file read data.
- Forms ALU operands A and B; B is either rt_data or a sign-extended immediate.
- Presents A, B and func to the ALU through a valid/ready handshake, with a 2-entry skid buffer so in_ready is a registered signal.

Parameters:
DATA_W, 32, operand/result width (A, B, C of ALU)
IMM_W, 16, immediate field width; sign-extended to DATA_W
FUNC_W, 4, ALU function code width

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
flush  in  1  discard all buffered entries (branch taken)
in_valid  in  1  upstream fields valid
in_ready  out  1  stage can accept; registered
rs_data  in  DATA_W  register source 1 -> ALU A
rt_data  in  DATA_W  register source 2
imm  in  IMM_W  immediate field
use_imm  in  1  1: B = sext(imm); 0: B = rt_data
func  in  FUNC_W  ALU function code
out_valid  out  1  alu_a/alu_b/alu_func valid
out_ready  in  1  ALU/downstream accepts
alu_a  out  DATA_W  operand A
alu_b  out  DATA_W  operand B
alu_func  out  FUNC_W  function code

Behaviour:
- Reset (rst=1 at posedge): both entries empty; out_valid=0, in_ready=1, alu_a=0, alu_b=0, alu_func=0.
- Operand formation happens at capture: B = use_imm ? {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm} : rt_data. A = rs_data. The stored entry holds the formed A, B and func.
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Storage: main register (drives outputs) plus a skid register. Latency is 1 cycle from input transfer to out_valid when the stage is empty.
- States, by occupancy:
  - EMPTY: out_valid=0.
  - ONE: main valid.
  - FULL: main and skid valid.
- Transitions:
  - EMPTY + in -> ONE.
  - ONE + in + out -> ONE (main replaced by new data).
  - ONE + in, no out -> FULL (new data to skid).
  - ONE + out, no in -> EMPTY.
  - FULL + out -> ONE (skid moves to main); in_ready=0 while FULL, so no input is accepted.
- in_ready = (state != FULL), registered. It deasserts the cycle after FULL is reached and reasserts the cycle after the draining output transfer.
- Output stability: while out_valid && !out_ready, alu_a/alu_b/alu_func are held constant.
- flush: next state is EMPTY and out_valid=0. A simultaneous input transfer is dropped and a simultaneous output transfer still counts. rst has priority over flush.
- Output data registers are not cleared on flush (don't-care when out_valid=0); they are cleared only on rst.
- No arithmetic is performed other than sign extension; there are no width-overflow cases.

Optional Feature:
- Macro STALL_CNT_EN.
- Defined: adds output port stall_cnt (32 bits), which increments every cycle with out_valid && !out_ready. It saturates at 32'hFFFF_FFFF, is cleared by rst, and is not cleared by flush.
- Undefined: no port and no counter; the stage is otherwise identical.

Decomposition:
- Shared package alu_pkg holds:
  - DATA_W, IMM_W, FUNC_W defaults.
  - FUNC encodings (FUNC_AND, FUNC_OR, FUNC_ADD, FUNC_SUB, FUNC_XOR, FUNC_SLL, FUNC_SRL, FUNC_SRA), shared with the ALU.
  - Occupancy state encoding.
- One natural sub-module: alu_skid_buf, a generic 2-entry valid/ready skid buffer of parameterised width. The top-level instantiates it with width DATA_W*2+FUNC_W and does the operand mux in front of it.

Test Plan:
- Reset, then rs=9, rt=33, use_imm=0, func=FUNC_AND, out_ready=1 -> next cycle out_valid=1, alu_a=9, alu_b=33, alu_func=FUNC_AND; in_ready stays 1.
- Immediate extension: imm=16'hFFF6, use_imm=1 -> alu_b=32'hFFFF_FFF6. Then imm=16'h000A -> alu_b=32'h0000_000A.
- Back-pressure: out_ready=0 and 3 back-to-back inputs (A=1,2,3) -> first two accepted, in_ready=0 after cycle 2, outputs hold A=1. Then out_ready=1 -> A=1, then A=2 delivered in order; third input accepted only after in_ready returns to 1.
- Flush while FULL with simultaneous in_valid -> next cycle out_valid=0, in_ready=1; no stale or dropped data appears afterwards.
- rst asserted mid-stream while FULL -> all outputs 0 next cycle, in_ready=1; with STALL_CNT_EN, stall_cnt=0.
- STALL_CNT_EN: hold out_ready=0 for 5 cycles with out_valid=1 -> stall_cnt=5; a flush leaves it at 5.
